// File: rtl/rename_pkg.sv
// Constants shared by the rename table and the physical free list.
package rename_pkg;
    localparam int TAG_W = 8;
    localparam logic [TAG_W-1:0] TAG_NO_RD = 8'd255;
    localparam logic [TAG_W-1:0] TAG_IMM   = 8'd254;
    localparam int ARCH_REGS = 32;
    localparam int NUM_PHYS  = 254;
    localparam int PAGES     = 8;
    localparam int PAGE_W    = $clog2(PAGES);
endpackage

// File: rtl/free_list_ckpt.sv
// Bank of head-pointer checkpoints, one per rename page.
module free_list_ckpt #(
    parameter int PAGES  = 8,
    parameter int PTR_W  = 9,
    parameter int PAGE_W = $clog2(PAGES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [PAGE_W-1:0] wr_page,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [PAGE_W-1:0] rd_page,
    output logic [PTR_W-1:0]  rd_ptr
);
    logic [PAGES-1:0][PTR_W-1:0] ckpt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ckpt <= '0;
        else if (wr_en)
            ckpt[wr_page] <= wr_ptr;
    end

    assign rd_ptr = ckpt[rd_page];
endmodule

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical tags with single-cycle checkpoint rollback of the head.
module phys_free_list #(
    parameter int TAG_W      = 8,
    parameter int DEPTH      = 256,
    parameter int FIRST_FREE = 32,
    parameter int NUM_FREE   = 222,
    parameter int PAGES      = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alloc_req,
    output logic [TAG_W-1:0]         alloc_tag,
    output logic                     alloc_valid,
    input  logic                     release_valid,
    input  logic [TAG_W-1:0]         release_tag,
    input  logic                     save_state,
    input  logic [$clog2(PAGES)-1:0] save_page,
    input  logic                     restore_state,
    input  logic [$clog2(PAGES)-1:0] restore_page,
    output logic [$clog2(DEPTH):0]   free_count,
    output logic                     overflow
);
    import rename_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [TAG_W-1:0] slot [DEPTH];
    logic [PTR_W-1:0] head, tail, head_nxt, ckpt_ptr, count;
    logic             empty, full, tag_ok, pop, push;

    assign count  = tail - head;
    assign empty  = (count == '0);
    assign full   = (count == PTR_W'(DEPTH));
    // No-Rd and immediate encodings are not real registers and never enter the list
    assign tag_ok = (release_tag != TAG_W'(TAG_NO_RD)) && (release_tag != TAG_W'(TAG_IMM));
    assign pop    = alloc_req && !empty && !restore_state;
    assign push   = release_valid && tag_ok && !full;

    assign head_nxt = restore_state ? ckpt_ptr : head + PTR_W'(pop);

    free_list_ckpt #(
        .PAGES (PAGES),
        .PTR_W (PTR_W)
    ) u_ckpt (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (save_state && !restore_state),
        .wr_page (save_page),
        .wr_ptr  (head_nxt),
        .rd_page (restore_page),
        .rd_ptr  (ckpt_ptr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                slot[i] <= (i < NUM_FREE) ? TAG_W'(FIRST_FREE + i) : '0;
        end else if (push) begin
            slot[tail[IDX_W-1:0]] <= release_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= PTR_W'(NUM_FREE);
            overflow <= 1'b0;
        end else begin
            head <= head_nxt;
            tail <= tail + PTR_W'(push);
            if (release_valid && tag_ok && full)
                overflow <= 1'b1;
        end
    end

    assign alloc_tag   = slot[head[IDX_W-1:0]];
    assign alloc_valid = !empty;
    assign free_count  = count;
endmodule

// File: tb/tb_phys_free_list.sv
// Directed scoreboard bench for phys_free_list: stimulus queues expected outputs, a negedge monitor checks them.
module tb_phys_free_list;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic [7:0] alloc_tag;
    logic       alloc_valid;
    logic       release_valid = 1'b0;
    logic [7:0] release_tag = 8'd0;
    logic       save_state = 1'b0;
    logic [2:0] save_page = 3'd0;
    logic       restore_state = 1'b0;
    logic [2:0] restore_page = 3'd0;
    logic [8:0] free_count;
    logic       overflow;

    phys_free_list dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .alloc_req     (alloc_req),
        .alloc_tag     (alloc_tag),
        .alloc_valid   (alloc_valid),
        .release_valid (release_valid),
        .release_tag   (release_tag),
        .save_state    (save_state),
        .save_page     (save_page),
        .restore_state (restore_state),
        .restore_page  (restore_page),
        .free_count    (free_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       chk_tag;
        logic [7:0] tag;
        logic       vld;
        logic [8:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expectation per cycle, compared away from the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (alloc_valid !== e.vld || free_count !== e.cnt || overflow !== e.ovf ||
                (e.chk_tag && alloc_tag !== e.tag)) begin
                errors++;
                $display("FAIL %s: got tag=%0d vld=%0b cnt=%0d ovf=%0b, want tag=%0d%s vld=%0b cnt=%0d ovf=%0b",
                         e.name, alloc_tag, alloc_valid, free_count, overflow,
                         e.tag, e.chk_tag ? "" : "(any)", e.vld, e.cnt, e.ovf);
            end
        end
    end

    task automatic exp_push(input string n, input logic ct, input logic [7:0] t,
                            input logic v, input logic [8:0] c, input logic o);
        exp_t x;
        x.name = n; x.chk_tag = ct; x.tag = t; x.vld = v; x.cnt = c; x.ovf = o;
        q.push_back(x);
    endtask

    task automatic step(input logic a, input logic rv, input logic [7:0] rt,
                        input logic sv, input logic [2:0] sp,
                        input logic rs, input logic [2:0] rp);
        alloc_req = a; release_valid = rv; release_tag = rt;
        save_state = sv; save_page = sp; restore_state = rs; restore_page = rp;
        @(posedge clk); #1;
        alloc_req = 0; release_valid = 0; release_tag = 0;
        save_state = 0; save_page = 0; restore_state = 0; restore_page = 0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset between edges; the following negedge sees only the async effect
    task automatic reset_pulse(input string n);
        @(posedge clk); #1;
        reset_n = 0;
        alloc_req = 0;
        exp_push(n, 1, 8'd32, 1, 9'd222, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
    endtask

    initial begin
        exp_push("reset", 1, 8'd32, 1, 9'd222, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        step(0, 0, 0, 0, 0, 0, 0);  exp_push("idle", 1, 8'd32, 1, 9'd222, 0);

        // Show-ahead pops
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("pop1", 1, 8'd33, 1, 9'd221, 0);
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("pop2", 1, 8'd34, 1, 9'd220, 0);
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("pop3", 1, 8'd35, 1, 9'd219, 0);

        // Drain, pop while empty, release with no bypass
        pop_n(219);                 exp_push("drained", 0, 8'd0, 0, 9'd0, 0);
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("pop_empty", 0, 8'd0, 0, 9'd0, 0);
        step(0, 1, 8'd7, 0, 0, 0, 0); exp_push("rel7", 1, 8'd7, 1, 9'd1, 0);

        // Checkpoint save / restore
        reset_pulse("reset2");
        pop_n(40);                  exp_push("pop40", 1, 8'd72, 1, 9'd182, 0);
        step(0, 0, 0, 1, 3'd2, 0, 0); exp_push("save2", 1, 8'd72, 1, 9'd182, 0);
        pop_n(5);                   exp_push("pop5", 1, 8'd77, 1, 9'd177, 0);
        step(1, 0, 0, 0, 0, 1, 3'd2); exp_push("rst_alloc", 1, 8'd72, 1, 9'd182, 0);
        step(1, 0, 0, 1, 3'd3, 0, 0); exp_push("pop_save3", 1, 8'd73, 1, 9'd181, 0);
        pop_n(4);                   exp_push("pop4", 1, 8'd77, 1, 9'd177, 0);
        step(0, 1, 8'd5, 0, 0, 1, 3'd2); exp_push("rst_rel", 1, 8'd72, 1, 9'd183, 0);
        step(0, 0, 0, 1, 3'd4, 1, 3'd3); exp_push("rst3", 1, 8'd73, 1, 9'd182, 0);
        step(0, 0, 0, 0, 0, 1, 3'd4); exp_push("rst4_nosave", 1, 8'd32, 1, 9'd223, 0);

        // Fill, overflow, reserved tags, pointer wrap
        reset_pulse("reset3");
        step(0, 1, 8'd254, 0, 0, 0, 0); exp_push("rel254", 1, 8'd32, 1, 9'd222, 0);
        step(0, 1, 8'd255, 0, 0, 0, 0); exp_push("rel255", 1, 8'd32, 1, 9'd222, 0);
        for (int i = 0; i < 34; i++) step(0, 1, 8'(i + 1), 0, 0, 0, 0);
        exp_push("full", 1, 8'd32, 1, 9'd256, 0);
        step(0, 1, 8'd50, 0, 0, 0, 0); exp_push("drop", 1, 8'd32, 1, 9'd256, 1);
        step(0, 1, 8'd255, 0, 0, 0, 0); exp_push("ovf_sticky", 1, 8'd32, 1, 9'd256, 1);
        pop_n(222);                 exp_push("pop222", 1, 8'd1, 1, 9'd34, 1);
        pop_n(34);                  exp_push("wrap_empty", 0, 8'd0, 0, 9'd0, 1);
        step(0, 1, 8'd9, 0, 0, 0, 0); exp_push("wrap_rel", 1, 8'd9, 1, 9'd1, 1);
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("wrap_pop", 0, 8'd0, 0, 9'd0, 1);

        // Asynchronous reset mid-burst
        reset_pulse("reset4");
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("burst1", 1, 8'd33, 1, 9'd221, 0);
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("burst2", 1, 8'd34, 1, 9'd220, 0);
        alloc_req = 1;
        reset_pulse("async_rst");
        step(0, 0, 0, 0, 0, 0, 0);  exp_push("post_rst", 1, 8'd32, 1, 9'd222, 0);
        step(1, 0, 0, 0, 0, 0, 0);  exp_push("post_pop", 1, 8'd33, 1, 9'd221, 0);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
